// File: rtl/unmask_pkg.sv
// Shared FSM encoding and sizing helper for the sequential share recombiner.
// The UNMASK_ZEROIZE_EN macro is consumed by shares_unmask_seq.
package unmask_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shares_unmask_seq_share_sel.sv
// Picks share number i_idx out of one bit's d-share vector.
module share_sel #(
    parameter int d  = 1,
    parameter int IW = 1
) (
    input  logic [d-1:0]  i_shares,
    input  logic [IW-1:0] i_idx,
    output logic          o_bit
);

    always_comb begin
        o_bit = 1'b0;
        for (int j = 0; j < d; j++) begin
            if (i_idx == IW'(j)) o_bit = i_shares[j];
        end
    end

endmodule

// File: rtl/shares_unmask_seq.sv
// Sequential unmasking: XORs one share per bit per cycle into an accumulator.
// Define UNMASK_ZEROIZE_EN to wipe consumed shares from the share register.
module shares_unmask_seq
    import unmask_pkg::*;
#(
    parameter int d     = 1,
    parameter int count = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [count*d-1:0] in_shares,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [count-1:0]   out,
    output logic               busy
);

    localparam int            IW   = idx_w(d);
    localparam logic [IW-1:0] LAST = IW'(d - 1);

    state_t               r_state;
    logic [count*d-1:0]   r_shares;
    logic [count-1:0]     r_acc;
    logic [IW-1:0]        r_idx;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [count-1:0]     w_sel;

    for (genvar gi = 0; gi < count; gi++) begin : g_sel
        share_sel #(
            .d  (d),
            .IW (IW)
        ) u_sel (
            .i_shares (r_shares[gi*d +: d]),
            .i_idx    (r_idx),
            .o_bit    (w_sel[gi])
        );
    end

`ifdef UNMASK_ZEROIZE_EN
    // one-hot of the share position being consumed, replicated per bit
    logic [count*d-1:0] w_clr;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < d; j++) begin
                if (r_idx == IW'(j)) w_clr[i*d+j] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shares    <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shares   <= in_shares;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_state    <= ACCUM;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc ^ w_sel;
`ifdef UNMASK_ZEROIZE_EN
                    r_shares <= r_shares & ~w_clr;
`endif
                    if (r_idx == LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
`ifdef UNMASK_ZEROIZE_EN
                        r_shares    <= '0;
`endif
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_acc;
    assign busy      = r_busy;

endmodule

// File: tb/tb_shares_unmask_seq.sv
// Bench for shares_unmask_seq: four configurations checked against a
// transaction-level model every cycle, plus hand-computed expectations.
module tb_shares_unmask_seq;

    localparam int DD [4] = '{2, 3, 4, 1};
    localparam int CC [4] = '{1, 4, 2, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [4];
    logic        iv   [4];
    logic        ordy [4];
    logic [15:0] sh   [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        bz   [4];
    logic [0:0]  o0;
    logic [3:0]  o1;
    logic [1:0]  o2, o3;
    logic [3:0]  ob   [4];

    always_comb begin
        ob[0] = {3'b0, o0};
        ob[1] = o1;
        ob[2] = {2'b0, o2};
        ob[3] = {2'b0, o3};
    end

    shares_unmask_seq #(.d(2), .count(1)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_shares(sh[0][1:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out(o0), .busy(bz[0]));
    shares_unmask_seq #(.d(3), .count(4)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_shares(sh[1][11:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out(o1), .busy(bz[1]));
    shares_unmask_seq #(.d(4), .count(2)) u2 (
        .clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_shares(sh[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out(o2), .busy(bz[2]));
    shares_unmask_seq #(.d(1), .count(2)) u3 (
        .clk(clk), .rst(rst[3]), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_shares(sh[3][1:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .out(o3), .busy(bz[3]));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // XOR of the first n shares of every bit
    function automatic logic [3:0] partial(int k, logic [15:0] s, int n);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < CC[k]; i++)
            for (int j = 0; j < n; j++)
                r[i] = r[i] ^ s[i*DD[k]+j];
        return r;
    endfunction

    // model: transaction in flight, ACCUM edges seen, result presented
    bit          mb   [4] = '{default: 1'b0};
    int          mcnt [4] = '{default: 0};
    bit          mv   [4] = '{default: 1'b0};
    logic [3:0]  mo   [4] = '{default: 4'h0};
    logic [15:0] msh  [4] = '{default: 16'h0};

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 4; k++) begin
            if (rst[k]) begin
                mb[k] = 1'b0;
                mv[k] = 1'b0;
                mo[k] = '0;
            end else if (!mb[k]) begin
                if (iv[k]) begin
                    mb[k]   = 1'b1;
                    mcnt[k] = 0;
                    msh[k]  = sh[k];
                    mo[k]   = '0;
                end
            end else if (!mv[k]) begin
                mcnt[k]++;
                mo[k] = partial(k, msh[k], mcnt[k]);
                if (mcnt[k] == DD[k]) mv[k] = 1'b1;
            end else if (ordy[k]) begin
                mb[k] = 1'b0;
                mv[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("model_ready%0d", k), 32'(ir[k]), 32'(!mb[k]));
            chk($sformatf("model_valid%0d", k), 32'(ov[k]), 32'(mv[k]));
            chk($sformatf("model_busy%0d", k), 32'(bz[k]), 32'(mb[k]));
            chk($sformatf("model_out%0d", k), 32'(ob[k]), 32'(mo[k]));
        end
    end

    task automatic accept(int k, logic [15:0] s);
        @(negedge clk);
        iv[k] = 1'b1;
        sh[k] = s;
        @(negedge clk);
        iv[k] = 1'b0;
    endtask

    // called at the negedge after the accepting edge
    task automatic wait_valid(int k, output int lat, output int low);
        lat = 1;
        low = 0;
        while (ov[k] !== 1'b1 && lat < 40) begin
            if (ir[k] === 1'b0) low++;
            @(negedge clk);
            lat++;
        end
        if (ir[k] === 1'b0) low++;
    endtask

    task automatic release_out(int k);
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
    endtask

    initial begin
        int lat, low, g;
        int tcyc [4];
        logic [1:0] tab [4];
        tab = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0; sh[k] = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", 32'(ir[k]), 1);
            chk("rst_valid", 32'(ov[k]), 0);
            chk("rst_out", 32'(ob[k]), 0);
            chk("rst_busy", 32'(bz[k]), 0);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // d=2: shares {1,0}, then stall in DONE with a stray in_valid
        accept(0, 16'h0001);
        wait_valid(0, lat, low);
        chk("t1_lat", lat, 3);
        chk("t1_out", 32'(ob[0]), 1);
`ifdef UNMASK_ZEROIZE_EN
        chk("t1_shreg", 32'(u0.r_shares), 0);
`else
        chk("t1_shreg", 32'(u0.r_shares), 1);
`endif
        iv[0] = 1'b1;
        sh[0] = 16'h0003;
        repeat (5) begin
            @(negedge clk);
            chk("t1_hold_out", 32'(ob[0]), 1);
            chk("t1_hold_valid", 32'(ov[0]), 1);
            chk("t1_hold_ready", 32'(ir[0]), 0);
        end
        iv[0] = 1'b0;
        release_out(0);
        chk("t1_idle_ready", 32'(ir[0]), 1);
        chk("t1_idle_out", 32'(ob[0]), 1);
        accept(0, 16'h0003);
        wait_valid(0, lat, low);
        chk("t1b_lat", lat, 3);
        chk("t1b_out", 32'(ob[0]), 0);
        release_out(0);

        // d=3, count=4: XOR result 4'b1010
        accept(1, 16'h0ECE);
        wait_valid(1, lat, low);
        chk("t2_lat", lat, 4);
        chk("t2_out", 32'(ob[1]), 32'hA);
        chk("t2_ready_low", low, 4);
        release_out(1);

        // d=4: reset at idx=2, then a clean transaction
        accept(2, 16'h00B6);
        @(negedge clk);
        @(negedge clk);
        #2 rst[2] = 1'b1;
        #1;
        chk("t3_rst_out", 32'(ob[2]), 0);
        chk("t3_rst_valid", 32'(ov[2]), 0);
        chk("t3_rst_ready", 32'(ir[2]), 1);
        chk("t3_rst_busy", 32'(bz[2]), 0);
        @(negedge clk);
        rst[2] = 1'b0;
        accept(2, 16'h00B6);
        wait_valid(2, lat, low);
        chk("t3_lat", lat, 5);
        chk("t3_out", 32'(ob[2]), 2);
        release_out(2);

        // d=1, count=2: continuous valid/ready streaming
        ordy[3] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            g = 0;
            while (ir[3] !== 1'b1 && g < 10) begin
                @(negedge clk);
                g++;
            end
            sh[3] = {14'h0, tab[n]};
            iv[3] = 1'b1;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (ov[3] !== 1'b1 && g < 10);
            tcyc[n] = cyc;
            chk("t4_lat", g, 2);
            chk("t4_out", 32'(ob[3]), 32'(tab[n]));
            if (n > 0) chk("t4_spacing", tcyc[n] - tcyc[n-1], 3);
        end
        iv[3] = 1'b0;
        @(negedge clk);
        ordy[3] = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
